// File: rtl/pe_window_detect.sv
// Per-pixel window membership for two rectangular windows with wrap-around bounds.
// Latency: one cycle from an accepted pixel to out_valid/win0/win1/obj.
// No backpressure: pixels past x=240 or coinciding with a line/frame start are dropped.
module pe_window_detect (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        pixel_valid,
    input  logic        obj_win_in,
    input  logic [15:0] win0h,
    input  logic [15:0] win0v,
    input  logic [15:0] win1h,
    input  logic [15:0] win1v,
    output logic        win0,
    output logic        win1,
    output logic        obj,
    output logic        out_valid,
    output logic [7:0]  x_pos,
    output logic [7:0]  y_pos
);

    localparam logic [7:0] X_MAX  = 8'd240;
    localparam logic [7:0] Y_LAST = 8'd227;
    localparam logic [7:0] Y_LIM  = 8'd228;

    // Bounds with lo > hi describe a window that wraps past the screen edge.
    function automatic logic span_hit(input logic [7:0] c, input logic [7:0] lo,
                                      input logic [7:0] hi);
        logic r;
        r = 1'b0;
        if (lo < hi)
            r = (c >= lo) && (c < hi);
        else if (lo > hi)
            r = (c >= lo) || (c < hi);
        return r;
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic [15:0] sh0h, sh0v, sh1h, sh1v;
    logic        vin0, vin1;

    logic        line_evt;
    logic        accept;
    logic [7:0]  y_next;
    logic        vin0_next, vin1_next;
    logic        hin0, hin1;

    always_comb begin
        line_evt  = frame_start | line_start;
        accept    = pixel_valid && !line_evt && (x_pos < X_MAX);
        y_next    = 8'd0;
        if (!frame_start && (y_pos != Y_LAST))
            y_next = y_pos + 8'd1;
        // Vertical flags use the incoming bounds, since they become the shadows on this edge.
        vin0_next = span_hit(y_next, win0v[15:8], clamp(win0v[7:0], Y_LIM));
        vin1_next = span_hit(y_next, win1v[15:8], clamp(win1v[7:0], Y_LIM));
        hin0      = span_hit(x_pos, clamp(sh0h[15:8], X_MAX), clamp(sh0h[7:0], X_MAX));
        hin1      = span_hit(x_pos, clamp(sh1h[15:8], X_MAX), clamp(sh1h[7:0], X_MAX));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_pos     <= 8'd0;
            y_pos     <= 8'd0;
            sh0h      <= 16'd0;
            sh0v      <= 16'd0;
            sh1h      <= 16'd0;
            sh1v      <= 16'd0;
            vin0      <= 1'b0;
            vin1      <= 1'b0;
            win0      <= 1'b0;
            win1      <= 1'b0;
            obj       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (line_evt) begin
                x_pos <= 8'd0;
                y_pos <= y_next;
                sh0h  <= win0h;
                sh0v  <= win0v;
                sh1h  <= win1h;
                sh1v  <= win1v;
                vin0  <= vin0_next;
                vin1  <= vin1_next;
            end else if (accept) begin
                x_pos     <= x_pos + 8'd1;
                win0      <= vin0 & hin0;
                win1      <= vin1 & hin1;
                obj       <= obj_win_in;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_window_detect.sv
// Randomised and directed bench for pe_window_detect against a per-pixel geometric model.
module tb_pe_window_detect;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        frame_start, line_start, pixel_valid, obj_win_in;
    logic [15:0] win0h, win0v, win1h, win1v;
    logic        win0, win1, obj, out_valid;
    logic [7:0]  x_pos, y_pos;

    pe_window_detect dut (
        .clock(clock), .reset_n(reset_n),
        .frame_start(frame_start), .line_start(line_start),
        .pixel_valid(pixel_valid), .obj_win_in(obj_win_in),
        .win0h(win0h), .win0v(win0v), .win1h(win1h), .win1v(win1v),
        .win0(win0), .win1(win1), .obj(obj), .out_valid(out_valid),
        .x_pos(x_pos), .y_pos(y_pos)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: screen position, latched bounds, expected outputs.
    int          mx, my;
    logic [15:0] m0h, m0v, m1h, m1v;
    bit          ew0, ew1, eobj, eval;
    int          cnt_v, cnt_w0, cnt_w1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lim(input int v, input int l);
        return (v > l) ? l : v;
    endfunction

    // A wrapped span is everything except the gap [hi, lo).
    function automatic bit in_span(input int c, input int lo, input int hi);
        if (lo == hi) return 1'b0;
        if (lo < hi)  return (c >= lo && c < hi);
        return !(c >= hi && c < lo);
    endfunction

    function automatic bit hit(input int x, input int y, input logic [15:0] h,
                               input logic [15:0] v);
        return in_span(x, lim(int'(h[15:8]), 240), lim(int'(h[7:0]), 240)) &&
               in_span(y, int'(v[15:8]), lim(int'(v[7:0]), 228));
    endfunction

    task automatic model_reset();
        mx = 0; my = 0;
        m0h = '0; m0v = '0; m1h = '0; m1v = '0;
        ew0 = 0; ew1 = 0; eobj = 0; eval = 0;
    endtask

    task automatic cycle(input bit fs, input bit ls, input bit pv, input bit ow);
        frame_start = fs; line_start = ls; pixel_valid = pv; obj_win_in = ow;
        eval = 0;
        if (fs || ls) begin
            mx  = 0;
            my  = fs ? 0 : (my + 1) % 228;
            m0h = win0h; m0v = win0v; m1h = win1h; m1v = win1v;
        end else if (pv && mx < 240) begin
            ew0  = hit(mx, my, m0h, m0v);
            ew1  = hit(mx, my, m1h, m1v);
            eobj = ow;
            eval = 1;
            mx++;
        end
        @(posedge clock);
        #1;
        check("out_valid", out_valid, eval);
        check("win0", win0, ew0);
        check("win1", win1, ew1);
        check("obj", obj, eobj);
        check("x_pos", x_pos, mx);
        check("y_pos", y_pos, my);
        if (out_valid) cnt_v++;
        if (out_valid && win0) cnt_w0++;
        if (out_valid && win1) cnt_w1++;
    endtask

    task automatic clr_cnt();
        cnt_v = 0; cnt_w0 = 0; cnt_w1 = 0;
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 1'($urandom_range(0, 1)));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_win0"}, win0, 0);
        check({tag, "_win1"}, win1, 0);
        check({tag, "_obj"}, obj, 0);
        check({tag, "_vld"}, out_valid, 0);
        check({tag, "_x"}, x_pos, 0);
        check({tag, "_y"}, y_pos, 0);
    endtask

    initial begin
        reset_n = 0;
        frame_start = 0; line_start = 0; pixel_valid = 0; obj_win_in = 0;
        win0h = '0; win0v = '0; win1h = '0; win1v = '0;
        model_reset();
        clr_cnt();
        repeat (3) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        @(negedge clock);
        reset_n = 1;

        // Pixels before any frame start: accepted, windows empty.
        win0h = 16'h00F0; win0v = 16'h00E4;
        pixels(20);
        check("pre_frame_vld", cnt_v, 20);
        check("pre_frame_w0", cnt_w0, 0);

        // Normal window: line 0 is outside rows 8..31, line 8 is inside.
        win0h = 16'h1040; win0v = 16'h0820;
        cycle(1, 0, 0, 0);
        clr_cnt(); pixels(240);
        check("norm_y0_w0", cnt_w0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
        clr_cnt(); pixels(240);
        check("norm_y8_w0", cnt_w0, 48);

        // Horizontal wrap on line 5.
        win1h = 16'hE010; win1v = 16'h00E4;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        clr_cnt(); pixels(240);
        check("wrap_w1", cnt_w1, 32);

        // Mid-line write is deferred to the next line.
        win0h = 16'h0010; win0v = 16'h00E4;
        cycle(0, 1, 0, 0);
        clr_cnt(); pixels(50);
        win0h = 16'h0020;
        pixels(190);
        check("midline_cur_w0", cnt_w0, 16);
        cycle(0, 1, 0, 0);
        clr_cnt(); pixels(240);
        check("midline_next_w0", cnt_w0, 32);

        // Overrun.
        cycle(0, 1, 0, 0);
        clr_cnt(); pixels(245);
        check("overrun_vld", cnt_v, 240);
        check("overrun_x", x_pos, 240);

        // Simultaneous frame/line/pixel at y=100.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 100; i++) cycle(0, 1, 0, 0);
        check("sim_pre_y", y_pos, 100);
        cycle(1, 1, 1, 1);
        check("sim_y", y_pos, 0);
        check("sim_x", x_pos, 0);
        cycle(0, 0, 0, 0);
        check("sim_next_vld", out_valid, 0);

        // Asynchronous reset mid-line with win0 high.
        win0h = 16'h0080; win0v = 16'h00E4;
        cycle(0, 1, 0, 0);
        pixels(121);
        check("arst_pre_w0", win0, 1);
        pixel_valid = 1;
        #2 reset_n = 0;
        #1 check_zero_outputs("arst");
        model_reset();
        @(negedge clock);
        frame_start = 0; line_start = 0; pixel_valid = 0;
        reset_n = 1;
        clr_cnt(); pixels(200);
        check("arst_after_w0", cnt_w0, 0);
        cycle(0, 1, 0, 0);
        clr_cnt(); pixels(240);
        check("arst_line_w0", cnt_w0, 128);

        // Random traffic, including out-of-range bounds and mid-line writes.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                win0h = 16'($urandom); win0v = 16'($urandom);
                win1h = 16'($urandom); win1v = 16'($urandom);
            end
            cycle(bit'($urandom_range(0, 1999) == 0), bit'($urandom_range(0, 199) == 0),
                  bit'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_window_detect.md
PE_WINDOW_DETECT -- requirements
Module: pe_window_detect

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 frame_start  input  1  one-cycle pulse at the first line of a frame.
REQ-005 line_start  input  1  one-cycle pulse at the start of each scanline.
REQ-006 pixel_valid  input  1  one pixel of the current line is being processed this cycle.
REQ-007 obj_win_in  input  1  object-window flag for the pixel qualified by pixel_valid.
REQ-008 win0h, win1h  input  16 each  horizontal bounds; [15:8] = left X1 (inclusive), [7:0] = right X2 (exclusive).
REQ-009 win0v, win1v  input  16 each  vertical bounds; [15:8] = top Y1 (inclusive), [7:0] = bottom Y2 (exclusive).
REQ-010 win0, win1  output  1 each  pixel lies inside window 0 / window 1.
REQ-011 obj  output  1  obj_win_in delayed to align with win0/win1.
REQ-012 out_valid  output  1  win0/win1/obj are valid this cycle.
REQ-013 x_pos  output  8  x of the next pixel to be accepted, range 0..240.
REQ-014 y_pos  output  8  current scanline, range 0..227.

Function
REQ-015 x_pos SHALL be set to 0 on any cycle with line_start or frame_start asserted.
REQ-016 On other cycles, x_pos SHALL increment by 1 on pixel_valid while x_pos < 240, and SHALL hold at 240.
REQ-017 A pixel_valid arriving with x_pos = 240 SHALL be ignored: no out_valid, no state change.
REQ-018 A pixel_valid in the same cycle as line_start or frame_start SHALL be ignored.
REQ-019 frame_start SHALL set y_pos to 0.
REQ-020 line_start without frame_start SHALL increment y_pos; 227 wraps to 0.
REQ-021 When frame_start and line_start coincide, frame_start SHALL take precedence: y_pos = 0.
REQ-022 Shadow copies of win0h/win0v/win1h/win1v SHALL be captured on any line_start or frame_start cycle; they SHALL be used for the whole following line; writes mid-line SHALL NOT affect it.
REQ-023 Per-line vertical flags vin0 and vin1 SHALL be registered on the same line_start/frame_start edge.
  - They are computed from the new y_pos value and the newly captured shadow values.
  - The rule is the inside rule of REQ-024, applied with Y1/Y2.
REQ-024 Inside rule for coordinate c with bounds A (lo) and B (hi):
  - A < B: inside iff A <= c < B.
  - A > B (wrap-around): inside iff c >= A or c < B.
  - A == B: never inside.
REQ-025 Horizontal bounds SHALL be clamped before comparison:
  - X2 > 240 is treated as 240; X1 > 240 is treated as 240.
  - Vertical Y2 > 228 is treated as 228.
REQ-026 For an accepted pixel at x = x_pos in cycle n, the following SHALL be registered so they are visible in cycle n+1 (latency 1):
  - win0 = vin0 AND hin0(x), and likewise for win1.
  - obj = obj_win_in.
  - out_valid = 1.
REQ-027 out_valid SHALL be 0 in every cycle not following an accepted pixel; win0/win1/obj SHALL hold their last values when out_valid = 0.
REQ-028 Before the first frame_start after reset:
  - Shadows are 0, so both windows are empty.
  - Pixels are still accepted, and win0/win1 = 0.

Reset
REQ-029 Asserting reset_n low SHALL asynchronously clear:
  - x_pos = 0, y_pos = 0.
  - vin0 = vin1 = 0 and all shadows = 0.
  - win0 = win1 = obj = out_valid = 0.
REQ-030 Reset asserted mid-line SHALL discard the in-flight pixel: out_valid = 0 in the cycle after release.
REQ-031 After release, the block SHALL wait for line_start or frame_start before producing a nonzero win0/win1.

Verification
REQ-032 Normal window:
  - Stimulus: win0h = 0x1040, win0v = 0x0820, frame_start, then 240 pixels.
  - Response: win0 = 1 exactly for x = 16..63 on y = 0, but only if 0 is in 8..31; here win0 = 0 on line 0.
  - Continuation: after 8 line_starts (y = 8), win0 = 1 for x = 16..63.
REQ-033 Horizontal wrap:
  - Stimulus: win1h = 0xE010, win1v = 0x00E4, line y = 5.
  - Response: win1 = 1 for x = 0..15 and x = 224..239, 0 otherwise.
REQ-034 Mid-line write:
  - Stimulus: change win0h from 0x0010 to 0x0020 at x = 50.
  - Response: the current line uses 0x0010 (win0 = 1 for x = 0..15); the next line uses x = 0..31.
REQ-035 Overrun:
  - Stimulus: 245 pixel_valid pulses in one line.
  - Response: exactly 240 out_valid pulses; x_pos holds at 240.
REQ-036 Simultaneous events:
  - Stimulus: frame_start, line_start and pixel_valid in the same cycle at y = 100.
  - Response: y_pos = 0, x_pos = 0, and no out_valid in the next cycle.
REQ-037 Async reset:
  - Stimulus: assert reset_n at x = 120 with win0 = 1.
  - Response: all outputs are 0 immediately, without waiting for a clock edge.
  - After release: win0 stays 0 until the next line_start.
